// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the parametrised UART receiver (and a future
// transmitter): FSM state encoding, parity-mode constants and a helper
// that derives the oversample clock divider from clock and baud rates.
// No ports.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Rounded clk cycles per oversample tick, e.g. 50 MHz / (115200 * 16) -> 27.
    function automatic int calc_clk_div(input int clk_hz, input int baud_hz, input int oversample);
        int tick_hz;
        tick_hz = baud_hz * oversample;
        return (clk_hz + tick_hz / 2) / tick_hz;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if
// Output handshake of the UART receiver toward the consumer (MMIO or FIFO).
//   data        received word, stable while data_valid=1
//   data_valid  word available, held until accepted
//   data_ready  consumer accepts when data_valid & data_ready
//   parity_err  parity flag of the presented word
//   framing_err framing flag of the presented word
//   overrun     one-cycle pulse when a frame is dropped
//   busy        receiver is inside a frame
// master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_err;
    logic                 framing_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output data, data_valid, parity_err, framing_err, overrun, busy,
        input  data_ready
    );

    modport slave (
        input  data, data_valid, parity_err, framing_err, overrun, busy,
        output data_ready
    );
endinterface

// File: rtl/uart_tick_gen.sv
// uart_tick_gen
// Free-running divider producing a one-clk oversample tick every CLK_DIV
// clocks. clear restarts the count so the next tick lands CLK_DIV clocks
// later, letting a receiver align bit timing to a start edge.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   clear  restart divider from 0
//   tick   one-clk pulse when divider is at CLK_DIV-1
module uart_tick_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign tick = (r_div == DIV_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param
// Parametrised asynchronous serial receiver with internal oversample tick,
// 3-sample majority vote, false-start rejection, parity/framing/overrun
// reporting and a valid/ready output handshake.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   rx     asynchronous serial line, idles high
//   rx_if  master side of uart_rx_param_if (data, data_valid, data_ready,
//          parity_err, framing_err, overrun, busy)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a falling edge on the synced line
// START    | validating start bit; majority 1 aborts as a false start
// DATA     | shifting DATA_BITS votes in, LSB first
// PARITY   | checking the parity bit (only when PARITY_MODE != 0)
// STOP     | checking stop bit(s); commits on the last stop-bit vote
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int CLK_DIV     = 27,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    uart_rx_param_if.master  rx_if
);
    localparam int              SC_W     = $clog2(OVERSAMPLE);
    localparam logic [SC_W-1:0] SC_V0    = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_V1    = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0] SC_V2    = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SC_W-1:0] SC_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam int              IDX_W    = 4;
    localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_next_state;

    logic                 r_rx_meta;
    logic                 r_rs;
    logic                 r_rs_prev;
    logic [SC_W-1:0]      r_sc;
    logic                 r_v0;
    logic                 r_v1;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr_out;
    logic                 r_ferr_out;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_fall;
    logic                 w_vote_evt;
    logic                 w_wrap;
    logic                 w_vote;
    logic                 w_clear_div;
    logic                 w_commit;
    logic                 w_busy;
    logic                 w_frm_now;
    logic                 w_par_xor;

    uart_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear_div),
        .tick  (w_tick)
    );

    // Synchronizer and edge-detect history idle high so reset never looks
    // like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rs      <= 1'b1;
            r_rs_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rs      <= r_rx_meta;
            r_rs_prev <= r_rs;
        end
    end

    assign w_fall     = r_rs_prev & ~r_rs;
    assign w_vote_evt = w_tick && (r_sc == SC_V2);
    assign w_wrap     = w_tick && (r_sc == SC_LAST);
    assign w_vote     = (r_v0 & r_v1) | (r_v0 & r_rs) | (r_v1 & r_rs);
    assign w_par_xor  = (^r_shift) ^ w_vote;
    assign w_frm_now  = r_frm_err | ~w_vote;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_next_state = ST_START;
            end
            ST_START: begin
                if (w_vote_evt && w_vote) w_next_state = ST_IDLE;
                else if (w_wrap)          w_next_state = ST_DATA;
            end
            ST_DATA: begin
                if (w_wrap && (r_idx == IDX_DATA_LAST))
                    w_next_state = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_wrap) w_next_state = ST_STOP;
            end
            ST_STOP: begin
                // Leave on the vote, not the wrap, so a back-to-back start
                // edge in the second half of the stop bit is still caught.
                if (w_vote_evt && (r_idx == IDX_STOP_LAST)) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_clear_div = 1'b0;
        w_commit    = 1'b0;
        w_busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: w_clear_div = w_fall;
            ST_STOP: w_commit    = w_vote_evt && (r_idx == IDX_STOP_LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sc <= '0;
        end else if (r_state == ST_IDLE) begin
            r_sc <= '0;
        end else if (w_tick) begin
            r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v0 <= 1'b1;
            r_v1 <= 1'b1;
        end else if (w_tick) begin
            if (r_sc == SC_V0) r_v0 <= r_rs;
            if (r_sc == SC_V1) r_v1 <= r_rs;
        end
    end

    // Bit index is reused as the stop-bit counter; it restarts whenever
    // the FSM moves to a new field.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (r_state == ST_IDLE) begin
            r_idx <= '0;
        end else if (w_wrap) begin
            r_idx <= (w_next_state != r_state) ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_par_err <= 1'b0;
                    r_frm_err <= 1'b0;
                end
                ST_DATA: begin
                    if (w_vote_evt) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                end
                ST_PARITY: begin
                    if (w_vote_evt)
                        r_par_err <= (PARITY_MODE == PARITY_ODD) ? ~w_par_xor : w_par_xor;
                end
                ST_STOP: begin
                    if (w_vote_evt && !w_vote) r_frm_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_commit) begin
                if (!r_valid || rx_if.data_ready) begin
                    r_data     <= r_shift;
                    r_perr_out <= r_par_err;
                    r_ferr_out <= w_frm_now;
                    r_valid    <= 1'b1;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end else if (r_valid && rx_if.data_ready) begin
                r_valid    <= 1'b0;
                r_perr_out <= 1'b0;
                r_ferr_out <= 1'b0;
            end
        end
    end

    assign rx_if.data        = r_data;
    assign rx_if.data_valid  = r_valid;
    assign rx_if.parity_err  = r_perr_out;
    assign rx_if.framing_err = r_ferr_out;
    assign rx_if.overrun     = r_overrun;
    assign rx_if.busy        = w_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
// Directed bench for uart_rx_param with CLK_DIV=4, OVERSAMPLE=16 (64 clk
// per bit). Three instances: 8N1, 8O1 (odd parity) and 8N2.
module tb_uart_rx_param;

    localparam int BIT_CLK = 64;

    logic clk = 1'b0;
    logic reset;
    logic rx0, rx1, rx2;
    int   cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(8)) if1 ();
    uart_rx_param_if #(.DATA_BITS(8)) if2 ();

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .CLK_DIV(4), .PARITY_MODE(0), .STOP_BITS(1))
        dut0 (.clk(clk), .reset(reset), .rx(rx0), .rx_if(if0));
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .CLK_DIV(4), .PARITY_MODE(2), .STOP_BITS(1))
        dut1 (.clk(clk), .reset(reset), .rx(rx1), .rx_if(if1));
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .CLK_DIV(4), .PARITY_MODE(0), .STOP_BITS(2))
        dut2 (.clk(clk), .reset(reset), .rx(rx2), .rx_if(if2));

    // Handshake monitor state, one slot per instance.
    int         acc_cnt [3] = '{0, 0, 0};
    logic [7:0] acc_data[3] = '{8'h0, 8'h0, 8'h0};
    logic       acc_perr[3] = '{1'b0, 1'b0, 1'b0};
    logic       acc_ferr[3] = '{1'b0, 1'b0, 1'b0};
    int         v_run   [3] = '{0, 0, 0};
    int         v_max   [3] = '{0, 0, 0};
    int         ovr_cnt [3] = '{0, 0, 0};
    int         ovr_run [3] = '{0, 0, 0};
    int         ovr_max [3] = '{0, 0, 0};
    logic       busy_prev0 = 1'b0;
    int         busy_fall_cyc = 0;
    int         start_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mon_step(input int k, input logic v, input logic r, input logic [7:0] d,
                            input logic pe, input logic fe, input logic ov);
        if (v && r) begin
            acc_cnt[k]++;
            acc_data[k] = d;
            acc_perr[k] = pe;
            acc_ferr[k] = fe;
        end
        if (v) begin
            v_run[k]++;
            if (v_run[k] > v_max[k]) v_max[k] = v_run[k];
        end else begin
            v_run[k] = 0;
        end
        if (ov) begin
            ovr_cnt[k]++;
            ovr_run[k]++;
            if (ovr_run[k] > ovr_max[k]) ovr_max[k] = ovr_run[k];
        end else begin
            ovr_run[k] = 0;
        end
    endtask

    // Sample mid-low-phase, after the bench has driven its negedge inputs.
    always @(negedge clk) begin
        #2;
        mon_step(0, if0.data_valid, if0.data_ready, if0.data, if0.parity_err, if0.framing_err, if0.overrun);
        mon_step(1, if1.data_valid, if1.data_ready, if1.data, if1.parity_err, if1.framing_err, if1.overrun);
        mon_step(2, if2.data_valid, if2.data_ready, if2.data, if2.parity_err, if2.framing_err, if2.overrun);
        if (busy_prev0 && !if0.busy) busy_fall_cyc = cyc;
        busy_prev0 = if0.busy;
    end

    task automatic set_rx(input int k, input logic v);
        case (k)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input int k, input logic v);
        set_rx(k, v);
        hold(BIT_CLK);
    endtask

    task automatic send_frame(input int k, input logic [7:0] d, input bit use_par, input logic pbit,
                              input int nstop, input logic st1, input logic st2);
        start_cyc = cyc;
        send_bit(k, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(k, d[i]);
        if (use_par) send_bit(k, pbit);
        send_bit(k, st1);
        if (nstop == 2) send_bit(k, st2);
        set_rx(k, 1'b1);
    endtask

    initial begin
        int base;
        int obase;
        int dlt;
        logic [7:0] gd;

        reset = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        if0.data_ready = 1'b1;
        if1.data_ready = 1'b1;
        if2.data_ready = 1'b1;
        hold(4);
        reset = 1'b0;
        hold(2);

        // Reset state
        check_eq("rst_data",   32'(if0.data), 32'h0);
        check_eq("rst_valid",  32'(if0.data_valid), 32'h0);
        check_eq("rst_perr",   32'(if0.parity_err), 32'h0);
        check_eq("rst_ferr",   32'(if0.framing_err), 32'h0);
        check_eq("rst_ovr",    32'(if0.overrun), 32'h0);
        check_eq("rst_busy",   32'(if0.busy), 32'h0);
        check_eq("rst_valid1", 32'(if1.data_valid), 32'h0);

        // 1: 8N1 0xA5, ready=1
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        hold(4);
        check_eq("t1_count", 32'(acc_cnt[0]), 32'd1);
        check_eq("t1_data",  32'(acc_data[0]), 32'hA5);
        check_eq("t1_perr",  32'(acc_perr[0]), 32'h0);
        check_eq("t1_ferr",  32'(acc_ferr[0]), 32'h0);
        check_eq("t1_vwidth", 32'(v_max[0]), 32'd1);
        dlt = busy_fall_cyc - (start_cyc + 9 * BIT_CLK + BIT_CLK / 2);
        check_eq("t1_busy_win", 32'(dlt >= 0 && dlt <= 40), 32'd1);
        check_eq("t1_busy_now", 32'(if0.busy), 32'h0);

        // 2: odd parity, 0x03 with parity 0 (bad) then 1 (good)
        send_frame(1, 8'h03, 1'b1, 1'b0, 1, 1'b1, 1'b1);
        hold(4);
        check_eq("t2_count_a", 32'(acc_cnt[1]), 32'd1);
        check_eq("t2_data_a",  32'(acc_data[1]), 32'h03);
        check_eq("t2_perr_a",  32'(acc_perr[1]), 32'h1);
        check_eq("t2_ferr_a",  32'(acc_ferr[1]), 32'h0);
        send_frame(1, 8'h03, 1'b1, 1'b1, 1, 1'b1, 1'b1);
        hold(4);
        check_eq("t2_count_b", 32'(acc_cnt[1]), 32'd2);
        check_eq("t2_data_b",  32'(acc_data[1]), 32'h03);
        check_eq("t2_perr_b",  32'(acc_perr[1]), 32'h0);

        // 3a: false start, 20 clk low
        base = acc_cnt[0];
        set_rx(0, 1'b0);
        hold(20);
        check_eq("t3_busy_in", 32'(if0.busy), 32'h1);
        set_rx(0, 1'b1);
        hold(100);
        check_eq("t3_busy_out", 32'(if0.busy), 32'h0);
        check_eq("t3_no_word",  32'(acc_cnt[0] - base), 32'd0);

        // 3b: 0x55 with a one-tick high glitch in data bit 3 (a 0 bit)
        gd = 8'h55;
        send_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                set_rx(0, 1'b0); hold(35);
                set_rx(0, 1'b1); hold(4);
                set_rx(0, 1'b0); hold(25);
            end else begin
                send_bit(0, gd[i]);
            end
        end
        send_bit(0, 1'b1);
        hold(4);
        check_eq("t3_glitch_cnt",  32'(acc_cnt[0] - base), 32'd1);
        check_eq("t3_glitch_data", 32'(acc_data[0]), 32'h55);
        check_eq("t3_glitch_ferr", 32'(acc_ferr[0]), 32'h0);

        // 4a: stop bit 0 on 0x3C
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        hold(4);
        check_eq("t4_data", 32'(acc_data[0]), 32'h3C);
        check_eq("t4_ferr", 32'(acc_ferr[0]), 32'h1);

        // 4b: two stop bits, clean then second stop 0
        send_frame(2, 8'hA5, 1'b0, 1'b0, 2, 1'b1, 1'b1);
        hold(4);
        check_eq("t4_2s_cnt_a",  32'(acc_cnt[2]), 32'd1);
        check_eq("t4_2s_data_a", 32'(acc_data[2]), 32'hA5);
        check_eq("t4_2s_ferr_a", 32'(acc_ferr[2]), 32'h0);
        send_frame(2, 8'h96, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        hold(4);
        check_eq("t4_2s_cnt_b",  32'(acc_cnt[2]), 32'd2);
        check_eq("t4_2s_data_b", 32'(acc_data[2]), 32'h96);
        check_eq("t4_2s_ferr_b", 32'(acc_ferr[2]), 32'h1);

        // Break: line low for 11 bit times yields one word 0x00 with framing error
        base = acc_cnt[0];
        set_rx(0, 1'b0);
        hold(11 * BIT_CLK);
        set_rx(0, 1'b1);
        hold(BIT_CLK);
        check_eq("brk_cnt",  32'(acc_cnt[0] - base), 32'd1);
        check_eq("brk_data", 32'(acc_data[0]), 32'h00);
        check_eq("brk_ferr", 32'(acc_ferr[0]), 32'h1);

        // 5: overrun, ready low, 0x11 then 0x22 back-to-back
        if0.data_ready = 1'b0;
        base  = acc_cnt[0];
        obase = ovr_cnt[0];
        send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        hold(4);
        check_eq("t5_valid",   32'(if0.data_valid), 32'h1);
        check_eq("t5_data",    32'(if0.data), 32'h11);
        check_eq("t5_ferr",    32'(if0.framing_err), 32'h0);
        check_eq("t5_ovr_cnt", 32'(ovr_cnt[0] - obase), 32'd1);
        check_eq("t5_ovr_w",   32'(ovr_max[0]), 32'd1);
        check_eq("t5_no_acc",  32'(acc_cnt[0] - base), 32'd0);
        if0.data_ready = 1'b1;
        hold(2);
        check_eq("t5_valid_low", 32'(if0.data_valid), 32'h0);
        check_eq("t5_acc_cnt",   32'(acc_cnt[0] - base), 32'd1);
        check_eq("t5_acc_data",  32'(acc_data[0]), 32'h11);
        hold(100);
        check_eq("t5_no_22", 32'(acc_cnt[0] - base), 32'd1);

        // 6: reset mid-DATA of 0xFF, then 0x42
        base = acc_cnt[0];
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        reset = 1'b1;
        hold(1);
        reset = 1'b0;
        check_eq("t6_busy_rst",  32'(if0.busy), 32'h0);
        check_eq("t6_valid_rst", 32'(if0.data_valid), 32'h0);
        hold(6 * BIT_CLK);
        check_eq("t6_no_partial", 32'(acc_cnt[0] - base), 32'd0);
        send_frame(0, 8'h42, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        hold(4);
        check_eq("t6_cnt",  32'(acc_cnt[0] - base), 32'd1);
        check_eq("t6_data", 32'(acc_data[0]), 32'h42);
        check_eq("t6_perr", 32'(acc_perr[0]), 32'h0);
        check_eq("t6_ferr", 32'(acc_ferr[0]), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
